fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Instruction fetch stage downstream of the program-counter counter. Reads instructions from
// instruction memory at the current pc over a req/ack handshake, buffers them in a small FIFO
// prefetch queue for decode, and drives the counter's advance/load controls (pc_advance, pc_load).
// Handles branch redirects by flushing the queue and discarding any in-flight read.
// PARAMETERS
// ADDR_WIDTH  8  width of pc / memory address
// DATA_WIDTH  8  width of one instruction word
// DEPTH       4  prefetch queue entries (power of two, >=2)
// PORTS
// clk            in   1           rising-edge clock
// reset          in   1           synchronous, active-high reset
// pc             in   ADDR_WIDTH  current program counter from counter.out
// pc_advance     out  1           1-cycle pulse: counter steps pc by +1
// pc_load        out  1           1-cycle pulse: counter loads pc_target
// pc_target      out  ADDR_WIDTH  redirect address, valid while pc_load=1
// mem_req        out  1           read request, held until mem_ack
// mem_addr       out  ADDR_WIDTH  read address, stable while mem_req=1
// mem_ack        in   1           read complete; mem_rdata valid this cycle
// mem_rdata      in   DATA_WIDTH  read data
// instr_valid    out  1           queue head valid (queue not empty)
// instr_data     out  DATA_WIDTH  queue head instruction
// instr_pc       out  ADDR_WIDTH  address the head instruction was fetched from
// instr_ready    in   1           decode accepts head; pop when instr_valid & instr_ready
// branch_valid   in   1           1-cycle redirect request
// branch_target  in   ADDR_WIDTH  redirect address
// BEHAVIOUR
// - Reset (sync, active-high, overrides all): state=IDLE, queue empty; mem_req, pc_advance,
//   pc_load, instr_valid = 0; mem_addr, pc_target = 0. Reset mid-read abandons it; a later
//   mem_ack while IDLE with no request outstanding is ignored.
// - Single outstanding read. States: IDLE, REQ, DRAIN, RESTART.
// - IDLE: if count<DEPTH and !branch_valid -> next cycle mem_req=1, mem_addr=pc (registered); ->REQ.
// - REQ: mem_req/mem_addr held. On mem_ack (no branch): push {mem_addr, mem_rdata}; pc_advance=1
//   next cycle for exactly one cycle; ->IDLE. Min issue-to-issue: ack cycle + 1 (one bubble).
// - Branch (branch_valid=1, any state): queue flushed at clock edge (count=0); pc_target<=branch_target;
//   pc_load=1 next cycle for one cycle. If REQ without ack this cycle -> DRAIN, else -> RESTART.
//   A mem_ack coinciding with branch_valid: data discarded, no pc_advance. Branch overrides pop.
// - DRAIN: mem_req held at old address until mem_ack; data discarded, no pc_advance; ->IDLE.
//   New branch in DRAIN: update pc_target, pulse pc_load again, stay DRAIN.
// - RESTART: one cycle, no issue (counter loads pc_target at end of pc_load cycle); ->IDLE.
// - pc_advance and pc_load never asserted in the same cycle; branch wins.
// - Queue: circular buffer, rd/wr pointers log2(DEPTH) bits wrap modulo DEPTH, count 0..DEPTH.
//   instr_valid = count!=0; instr_data/instr_pc driven from head entry (no extra latency).
//   Simultaneous push+pop: count unchanged. Push never occurs when full (issue needs count<DEPTH).
//   Pop on empty impossible (instr_valid=0).
// - instr_pc equals the address of the read that produced instr_data, never the live pc.
// TESTING
// 1 Reset: assert reset 2 cycles mid-REQ -> all outputs 0, instr_valid=0, stray mem_ack ignored.
// 2 Stream: pc=0x10, mem_ack 1 cycle after each req, rdata=0xA0.. , ready=1 -> decode sees
//   (0x10,0xA0),(0x11,0xA1).. in order, one pc_advance per ack, 2-cycle issue spacing.
// 3 Full: ready=0, DEPTH=4 -> exactly 4 fetches then mem_req stays 0; one pop -> exactly one new read.
// 4 Branch mid-read: req to 0x12 pending, branch_valid target=0x40 -> queue empty next cycle,
//   pc_load=1 pc_target=0x40, ack for 0x12 discarded, next mem_addr=0x40.
// 5 Branch same cycle as mem_ack and pop -> no push, no pc_advance, pc_load pulse, instr_valid=0.
// 6 Pointer wrap: 10 fetches with interleaved pops (push+pop same cycle) -> order/pc preserved, count correct.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one read at a time at the current pc,
// buffers returned instructions (with their fetch address) in a small
// circular prefetch queue, and pulses pc_advance / pc_load to steer the
// external program counter. A branch flushes the queue and discards any
// read still in flight.
//
// Handshakes:
//   mem:   mem_req rises with mem_addr and both hold until mem_ack; the read
//          completes in the cycle mem_ack=1 (mem_rdata valid that cycle).
//   instr: the head entry transfers when instr_valid & instr_ready are both 1
//          at a rising edge; instr_data/instr_pc are stable while instr_valid=1
//          and no transfer or branch occurs.
module fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_advance,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [1:0]            state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DRAIN   = 2'd2,
    RESTART = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  pc_advance_q, pc_advance_d;
  logic                  pc_load_q, pc_load_d;
  logic [ADDR_WIDTH-1:0] pc_target_q, pc_target_d;

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];

  logic push;
  logic pop;
  logic flush;

  // FSM next state and registered control outputs
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pc_advance_d = 1'b0;
    pc_load_d    = 1'b0;
    pc_target_d  = pc_target_q;
    push         = 1'b0;
    flush        = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_valid) begin
          state_d = RESTART;
        end else if (count_q != FULL_CNT) begin
          // While pc_advance is high the counter has not stepped yet, so
          // the address it is about to hold is forwarded here; this keeps
          // issue spacing at a single bubble after each ack.
          mem_req_d  = 1'b1;
          mem_addr_d = pc_advance_q ? (pc + ADDR_WIDTH'(1)) : pc;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (branch_valid) begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = RESTART;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ack) begin
          push         = 1'b1;
          pc_advance_d = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      DRAIN: begin
        // Stale read completes here; data is dropped. A branch on the same
        // cycle still needs a restart cycle for its own pc_load.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = branch_valid ? RESTART : IDLE;
        end
      end
      RESTART: begin
        state_d = branch_valid ? RESTART : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (branch_valid) begin
      flush       = 1'b1;
      pc_load_d   = 1'b1;
      pc_target_d = branch_target;
    end
  end

  // FSM and control output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pc_advance_q <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_target_q  <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pc_advance_q <= pc_advance_d;
      pc_load_q    <= pc_load_d;
      pc_target_q  <= pc_target_d;
    end
  end

  assign pop = (count_q != '0) && instr_ready && !branch_valid;

  // Queue pointer, count and storage updates; a branch flush wins over push/pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    addr_d   = addr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = mem_rdata;
        addr_d[wr_ptr_q] = mem_addr_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    data_q <= data_d;
    addr_q <= addr_d;
  end

  assign pc_advance  = pc_advance_q;
  assign pc_load     = pc_load_q;
  assign pc_target   = pc_target_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = (count_q != '0);
  assign instr_data  = data_q[rd_ptr_q];
  assign instr_pc    = addr_q[rd_ptr_q];
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an external pc counter model, a zero-wait
// memory responder driven per cycle, and an expected queue of (pc,instr)
// pairs compared against what decode pops.
module tb_fetch_unit;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DRAIN = 2'd2, S_RESTART = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] pc;
  logic       pc_advance, pc_load;
  logic [7:0] pc_target;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic [7:0] instr_data, instr_pc;
  logic       instr_ready;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic [1:0] state_dbg;

  logic       pc_set;
  logic [7:0] pc_set_val;

  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .pc_advance(pc_advance), .pc_load(pc_load), .pc_target(pc_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .branch_valid(branch_valid), .branch_target(branch_target),
    .state_dbg(state_dbg)
  );

  // external program counter: load wins over advance
  always @(posedge clk) begin
    if (pc_set) pc <= pc_set_val;
    else if (pc_load) pc <= pc_target;
    else if (pc_advance) pc <= pc + 8'd1;
  end

  // scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int issue_cyc[$];
  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int adv_cnt = 0;
  int cyc_n   = 0;
  logic req_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // one clock: drive inputs for this cycle, observe, then advance
  task automatic step(input logic ack_en, input logic rdy, input logic br, input logic [7:0] tgt);
    mem_ack       = ack_en & mem_req;
    mem_rdata     = mem_addr + 8'h90;
    instr_ready   = rdy;
    branch_valid  = br;
    branch_target = tgt;
    check("adv_load_excl", {31'd0, pc_advance & pc_load}, 32'd0);
    if (instr_valid && rdy && !br) obs_q.push_back({instr_pc, instr_data});
    if (mem_req && mem_ack) ack_cnt++;
    if (pc_advance) adv_cnt++;
    if (mem_req && !req_prev) issue_cyc.push_back(cyc_n);
    req_prev = mem_req;
    cyc_n++;
    cycle();
    mem_ack      = 1'b0;
    branch_valid = 1'b0;
  endtask

  task automatic check_pops(input string tag);
    check({tag, "_n"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, {16'd0, obs_q[i]}, {16'd0, exp_q[i]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_set = 1'b1; pc_set_val = 8'h10;
    mem_ack = 1'b0; mem_rdata = 8'h00; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = 8'h00;

    // ---- 1: reset mid-REQ, stray ack ignored ----
    cycle(); cycle();
    reset = 1'b0; pc_set = 1'b0;
    cycle();
    check("pre_reset_req", {31'd0, mem_req}, 32'd1);
    check("pre_reset_addr", {24'd0, mem_addr}, 32'h10);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h55;
    cycle(); cycle();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_pc_adv", {31'd0, pc_advance}, 32'd0);
    check("rst_pc_load", {31'd0, pc_load}, 32'd0);
    check("rst_pc_target", {24'd0, pc_target}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    reset = 1'b0;
    cycle();
    mem_ack = 1'b0;
    check("stray_valid", {31'd0, instr_valid}, 32'd0);
    check("stray_adv", {31'd0, pc_advance}, 32'd0);
    check("stray_req", {31'd0, mem_req}, 32'd1);
    check("stray_addr", {24'd0, mem_addr}, 32'h10);
    check("stray_state", {30'd0, state_dbg}, {30'd0, S_REQ});

    // ---- 2: streaming with ready=1 ----
    req_prev = 1'b1; cyc_n = 0; ack_cnt = 0; adv_cnt = 0;
    issue_cyc.delete(); obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({8'h10 + 8'(i), 8'hA0 + 8'(i)});
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
    check_pops("stream_pop");
    check("stream_acks", ack_cnt, 32'd6);
    check("stream_advs", adv_cnt, 32'd6);
    check("stream_issues", issue_cyc.size(), 32'd5);
    for (int i = 1; i < issue_cyc.size(); i++)
      check("stream_spacing", issue_cyc[i] - issue_cyc[i-1], 32'd2);

    // ---- 3: queue full with ready=0 ----
    ack_cnt = 0; obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    check("full_acks", ack_cnt, 32'd4);
    check("full_req", {31'd0, mem_req}, 32'd0);
    check("full_head_pc", {24'd0, instr_pc}, 32'h16);
    check("full_head_data", {24'd0, instr_data}, 32'hA6);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    exp_q.push_back(16'h16A6);
    check_pops("full_pop");
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    check("refill_acks", ack_cnt, 32'd1);
    check("refill_req", {31'd0, mem_req}, 32'd0);
    check("refill_head_pc", {24'd0, instr_pc}, 32'h17);

    // ---- 4: branch while a read is pending ----
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("br4_req_held", {31'd0, mem_req}, 32'd1);
    check("br4_addr_held", {24'd0, mem_addr}, 32'h1B);
    check("br4_valid_pre", {31'd0, instr_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h40);
    check("br4_valid", {31'd0, instr_valid}, 32'd0);
    check("br4_load", {31'd0, pc_load}, 32'd1);
    check("br4_target", {24'd0, pc_target}, 32'h40);
    check("br4_adv", {31'd0, pc_advance}, 32'd0);
    check("br4_drain_addr", {24'd0, mem_addr}, 32'h1B);
    check("br4_state", {30'd0, state_dbg}, {30'd0, S_DRAIN});
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("br4_discard_valid", {31'd0, instr_valid}, 32'd0);
    check("br4_discard_adv", {31'd0, pc_advance}, 32'd0);
    check("br4_load_pulse", {31'd0, pc_load}, 32'd0);
    check("br4_idle_req", {31'd0, mem_req}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("br4_new_req", {31'd0, mem_req}, 32'd1);
    check("br4_new_addr", {24'd0, mem_addr}, 32'h40);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("br4_push_pc", {24'd0, instr_pc}, 32'h40);
    check("br4_push_data", {24'd0, instr_data}, 32'hD0);
    check("br4_push_adv", {31'd0, pc_advance}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // ---- 5: branch with mem_ack and pop in the same cycle ----
    check("br5_pre_valid", {31'd0, instr_valid}, 32'd1);
    check("br5_pre_req_addr", {24'd0, mem_addr}, 32'h42);
    step(1'b1, 1'b1, 1'b1, 8'h80);
    check("br5_valid", {31'd0, instr_valid}, 32'd0);
    check("br5_adv", {31'd0, pc_advance}, 32'd0);
    check("br5_load", {31'd0, pc_load}, 32'd1);
    check("br5_target", {24'd0, pc_target}, 32'h80);
    check("br5_req", {31'd0, mem_req}, 32'd0);
    check("br5_state", {30'd0, state_dbg}, {30'd0, S_RESTART});
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("br5_restart_req", {31'd0, mem_req}, 32'd0);
    check("br5_idle", {30'd0, state_dbg}, {30'd0, S_IDLE});
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("br5_new_req", {31'd0, mem_req}, 32'd1);
    check("br5_new_addr", {24'd0, mem_addr}, 32'h80);

    // ---- 6: pointer wrap with push+pop in the same cycle ----
    ack_cnt = 0; obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back({8'h80 + 8'(i), 8'h10 + 8'(i)});
    for (int g = 0; g < 100 && ack_cnt < 10; g++) step(1'b1, mem_req, 1'b0, 8'h00);
    check("wrap_acks", ack_cnt, 32'd10);
    check("wrap_one_left", {31'd0, instr_valid}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("wrap_empty", {31'd0, instr_valid}, 32'd0);
    check_pops("wrap_pop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
